// File: rtl/config_pkg.sv
`default_nettype none
// ============================================================================
// Module   : config_pkg
// Brief    : Shared interrupt vector sizing for the pend controller and CLIC.
// Revision : 1.0 - initial release
// ============================================================================
package config_pkg;

  localparam int IrqVecSize = 8;

  typedef logic [$clog2(IrqVecSize)-1:0] irq_idx_t;

endpackage
`default_nettype wire

// File: rtl/irq_line_cond.sv
`default_nettype none
// ============================================================================
// Module   : irq_line_cond
// Brief    : Synchroniser plus optional glitch filter for one interrupt line.
//            Filter enabled by defining IRQ_PEND_GLITCH_FILTER_EN.
// Revision : 1.0 - initial release
// ============================================================================
module irq_line_cond #(
  parameter int SyncStages   = 2,
  parameter int FilterCycles = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic irq_in,
  output logic lvl
);

  logic [SyncStages-1:0] r_sync;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SyncStages-2:0], irq_in};
    end
  end

`ifdef IRQ_PEND_GLITCH_FILTER_EN
  localparam int CntW = $clog2(FilterCycles + 1);
  localparam logic [CntW-1:0] c_cnt_last = CntW'(FilterCycles - 1);

  logic [CntW-1:0] r_cnt;
  logic            r_lvl;

  // Counts consecutive cycles of disagreement; any agreement restarts the run.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
      r_lvl <= 1'b0;
    end else if (r_sync[SyncStages-1] == r_lvl) begin
      r_cnt <= '0;
    end else if (r_cnt == c_cnt_last) begin
      r_cnt <= '0;
      r_lvl <= ~r_lvl;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign lvl = r_lvl;
`else
  assign lvl = r_sync[SyncStages-1];
`endif

endmodule
`default_nettype wire

// File: rtl/irq_pend_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : irq_pend_ctrl
// Brief    : Per-vector interrupt pend/lost tracking upstream of the CLIC.
//            Optional glitch filter: IRQ_PEND_GLITCH_FILTER_EN.
// Revision : 1.0 - initial release
// ============================================================================
module irq_pend_ctrl
  import config_pkg::*;
#(
  parameter int VecSize      = IrqVecSize,
  parameter int SyncStages   = 2,
  parameter int FilterCycles = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [VecSize-1:0]         irq_in,
  input  logic [VecSize-1:0]         edge_mode,
  input  logic [VecSize-1:0]         sw_set,
  input  logic [VecSize-1:0]         sw_clr,
  input  logic                       take_ack,
  input  logic [$clog2(VecSize)-1:0] take_idx,
  input  logic [VecSize-1:0]         lost_clr,
  output logic [VecSize-1:0]         pend_out,
  output logic [VecSize-1:0]         lost_out
);

  logic [VecSize-1:0] w_lvl;
  logic [VecSize-1:0] w_rise;
  logic [VecSize-1:0] w_clr;
  logic [VecSize-1:0] w_pend_nxt;
  logic [VecSize-1:0] w_lost_nxt;
  logic [VecSize-1:0] r_prev;
  logic [VecSize-1:0] r_pend;
  logic [VecSize-1:0] r_lost;

  for (genvar k = 0; k < VecSize; k++) begin : g_line
    irq_line_cond #(
      .SyncStages  (SyncStages),
      .FilterCycles(FilterCycles)
    ) u_cond (
      .clk   (clk),
      .reset (reset),
      .irq_in(irq_in[k]),
      .lvl   (w_lvl[k])
    );
  end

  assign w_rise = w_lvl & ~r_prev;

  // An index outside the vector range never matches, so it is ignored.
  always_comb begin
    w_clr = sw_clr;
    for (int k = 0; k < VecSize; k++) begin
      if (take_ack && (int'(take_idx) == k)) begin
        w_clr[k] = 1'b1;
      end
    end
  end

  always_comb begin
    w_pend_nxt = r_pend;
    w_lost_nxt = r_lost & ~lost_clr;
    for (int k = 0; k < VecSize; k++) begin
      if (edge_mode[k]) begin
        if (w_rise[k] || sw_set[k]) begin
          w_pend_nxt[k] = 1'b1;
        end else if (w_clr[k]) begin
          w_pend_nxt[k] = 1'b0;
        end
        // Only an edge on a pended vector with no same-cycle retire is lost.
        if (w_rise[k] && r_pend[k] && !w_clr[k]) begin
          w_lost_nxt[k] = 1'b1;
        end
      end else begin
        w_pend_nxt[k] = w_lvl[k] | sw_set[k];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_prev <= '0;
      r_pend <= '0;
      r_lost <= '0;
    end else begin
      r_prev <= w_lvl;
      r_pend <= w_pend_nxt;
      r_lost <= w_lost_nxt;
    end
  end

  assign pend_out = r_pend;
  assign lost_out = r_lost;

endmodule
`default_nettype wire

// File: tb/tb_irq_pend_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_irq_pend_ctrl
// Brief    : Self-checking bench for irq_pend_ctrl (honours
//            IRQ_PEND_GLITCH_FILTER_EN when defined).
// Revision : 1.0 - initial release
// ============================================================================
module tb_irq_pend_ctrl;
  import config_pkg::*;

  localparam int V    = IrqVecSize;
  localparam int SYNC = 2;
  localparam int FILT = 4;
`ifdef IRQ_PEND_GLITCH_FILTER_EN
  localparam int LAT = SYNC + FILT + 1;
`else
  localparam int LAT = SYNC + 1;
`endif

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic [V-1:0]         irq_in = '0;
  logic [V-1:0]         edge_mode = '1;
  logic [V-1:0]         sw_set = '0;
  logic [V-1:0]         sw_clr = '0;
  logic                 take_ack = 1'b0;
  logic [$clog2(V)-1:0] take_idx = '0;
  logic [V-1:0]         lost_clr = '0;
  logic [V-1:0]         pend_out;
  logic [V-1:0]         lost_out;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  irq_pend_ctrl #(
    .VecSize     (V),
    .SyncStages  (SYNC),
    .FilterCycles(FILT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .irq_in   (irq_in),
    .edge_mode(edge_mode),
    .sw_set   (sw_set),
    .sw_clr   (sw_clr),
    .take_ack (take_ack),
    .take_idx (take_idx),
    .lost_clr (lost_clr),
    .pend_out (pend_out),
    .lost_out (lost_out)
  );

  // Reference model: raw samples kept in a history queue, conditioned level
  // read back from that history, pend/lost rules applied per vector.
  logic [V-1:0] m_pend = '0;
  logic [V-1:0] m_lost = '0;
  logic [V-1:0] m_prev = '0;
  logic [V-1:0] m_lvl  = '0;
  logic [V-1:0] samp_q[$];
  logic [V-1:0] sync_q[$];

  initial begin : model
    logic [V-1:0] rise;
    logic [V-1:0] s_before;
    logic         clr;
    logic         all_diff;
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        m_pend = '0;
        m_lost = '0;
        m_prev = '0;
        m_lvl  = '0;
        samp_q.delete();
        sync_q.delete();
      end else begin
        rise = m_lvl & ~m_prev;
        for (int k = 0; k < V; k++) begin
          clr = sw_clr[k] || (take_ack && (int'(take_idx) == k));
          if (edge_mode[k]) begin
            if (rise[k] && m_pend[k] && !clr) m_lost[k] = 1'b1;
            else if (lost_clr[k])             m_lost[k] = 1'b0;
            if (rise[k] || sw_set[k]) m_pend[k] = 1'b1;
            else if (clr)             m_pend[k] = 1'b0;
          end else begin
            if (lost_clr[k]) m_lost[k] = 1'b0;
            m_pend[k] = m_lvl[k] | sw_set[k];
          end
        end
        m_prev   = m_lvl;
        s_before = (samp_q.size() >= SYNC) ? samp_q[samp_q.size()-SYNC] : '0;
        samp_q.push_back(irq_in);
`ifdef IRQ_PEND_GLITCH_FILTER_EN
        sync_q.push_back(s_before);
        for (int k = 0; k < V; k++) begin
          all_diff = (sync_q.size() >= FILT);
          for (int j = 1; j <= FILT && all_diff; j++) begin
            if (sync_q[sync_q.size()-j][k] == m_lvl[k]) all_diff = 1'b0;
          end
          if (all_diff) m_lvl[k] = ~m_lvl[k];
        end
`else
        all_diff = 1'b0;
        sync_q.push_back(s_before);
        m_lvl = (samp_q.size() >= SYNC) ? samp_q[samp_q.size()-SYNC] : '0;
`endif
        while (samp_q.size() > 32) void'(samp_q.pop_front());
        while (sync_q.size() > 32) void'(sync_q.pop_front());
      end
    end
  end

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (pend_out !== '0) begin
      n_err++; $display("FAIL reset_pend got=%h want=%h", pend_out, {V{1'b0}});
    end
    n_cmp++;
    if (lost_out !== '0) begin
      n_err++; $display("FAIL reset_lost got=%h want=%h", lost_out, {V{1'b0}});
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_edge_basic();
    irq_in[3] = 1'b1;
    for (int c = 1; c <= LAT + 4; c++) begin
      @(negedge clk);
      n_cmp++;
      if (pend_out[3] !== (c >= LAT)) begin
        n_err++; $display("FAIL edge_latency c=%0d got=%b want=%b", c, pend_out[3], (c >= LAT));
      end
    end
    take_ack = 1'b1;
    take_idx = 3;
    @(negedge clk);
    take_ack = 1'b0;
    n_cmp++;
    if (pend_out[3] !== 1'b0) begin
      n_err++; $display("FAIL edge_ack got=%b want=0", pend_out[3]);
    end
    n_cmp++;
    if (pend_out !== m_pend) begin
      n_err++; $display("FAIL edge_model got=%h want=%h", pend_out, m_pend);
    end
  endtask

  task automatic test_lost();
    irq_in[3] = 1'b0;
    repeat (LAT + 2) @(negedge clk);
    irq_in[3] = 1'b1;
    repeat (LAT + 1) @(negedge clk);
    irq_in[3] = 1'b0;
    repeat (LAT + 2) @(negedge clk);
    n_cmp++;
    if (lost_out[3] !== 1'b0 || pend_out[3] !== 1'b1) begin
      n_err++; $display("FAIL lost_pre got=%b/%b want=1/0", pend_out[3], lost_out[3]);
    end
    irq_in[3] = 1'b1;
    repeat (LAT + 1) @(negedge clk);
    n_cmp++;
    if (lost_out[3] !== 1'b1) begin
      n_err++; $display("FAIL lost_set got=%b want=1", lost_out[3]);
    end
    lost_clr[3] = 1'b1;
    @(negedge clk);
    lost_clr[3] = 1'b0;
    n_cmp++;
    if (lost_out[3] !== 1'b0) begin
      n_err++; $display("FAIL lost_clear got=%b want=0", lost_out[3]);
    end
    irq_in[3] = 1'b0;
    repeat (LAT + 2) @(negedge clk);
    irq_in[3] = 1'b1;
    repeat (LAT - 1) @(negedge clk);
    take_ack = 1'b1;
    take_idx = 3;
    @(negedge clk);
    take_ack = 1'b0;
    n_cmp++;
    if (pend_out[3] !== 1'b1 || lost_out[3] !== 1'b0) begin
      n_err++; $display("FAIL edge_with_ack got=%b/%b want=1/0", pend_out[3], lost_out[3]);
    end
    n_cmp++;
    if (lost_out !== m_lost) begin
      n_err++; $display("FAIL lost_model got=%h want=%h", lost_out, m_lost);
    end
    sw_clr[3] = 1'b1;
    @(negedge clk);
    sw_clr[3] = 1'b0;
  endtask

  task automatic test_level();
    edge_mode[5] = 1'b0;
    irq_in[5]    = 1'b1;
    repeat (LAT) @(negedge clk);
    take_ack = 1'b1;
    take_idx = 5;
    @(negedge clk);
    take_ack = 1'b0;
    n_cmp++;
    if (pend_out[5] !== 1'b1) begin
      n_err++; $display("FAIL level_ack_ignored got=%b want=1", pend_out[5]);
    end
    irq_in[5] = 1'b0;
    for (int c = 1; c <= LAT + 1; c++) begin
      @(negedge clk);
      n_cmp++;
      if (pend_out[5] !== (c < LAT)) begin
        n_err++; $display("FAIL level_drop c=%0d got=%b want=%b", c, pend_out[5], (c < LAT));
      end
    end
    edge_mode[5] = 1'b1;
  endtask

  task automatic test_sw();
    sw_set[0] = 1'b1;
    sw_clr[0] = 1'b1;
    @(negedge clk);
    sw_set[0] = 1'b0;
    n_cmp++;
    if (pend_out[0] !== 1'b1) begin
      n_err++; $display("FAIL sw_set_wins got=%b want=1", pend_out[0]);
    end
    @(negedge clk);
    sw_clr[0] = 1'b0;
    n_cmp++;
    if (pend_out[0] !== 1'b0) begin
      n_err++; $display("FAIL sw_clr got=%b want=0", pend_out[0]);
    end
  endtask

  task automatic test_pulse();
    logic seen;
    seen = 1'b0;
    irq_in[1] = 1'b1;
    for (int c = 1; c <= LAT + 4; c++) begin
      @(negedge clk);
      if (pend_out[1]) seen = 1'b1;
      if (c == 3) irq_in[1] = 1'b0;
    end
    n_cmp++;
`ifdef IRQ_PEND_GLITCH_FILTER_EN
    if (seen !== 1'b0) begin
      n_err++; $display("FAIL short_pulse got=%b want=0", seen);
    end
`else
    if (seen !== 1'b1) begin
      n_err++; $display("FAIL short_pulse got=%b want=1", seen);
    end
`endif
    sw_clr[1] = 1'b1;
    @(negedge clk);
    sw_clr[1] = 1'b0;
    irq_in[1] = 1'b1;
    for (int c = 1; c <= LAT + 2; c++) begin
      @(negedge clk);
      if (c == LAT - 1 || c == LAT) begin
        n_cmp++;
        if (pend_out[1] !== (c == LAT)) begin
          n_err++; $display("FAIL long_pulse c=%0d got=%b want=%b", c, pend_out[1], (c == LAT));
        end
      end
      if (c == 6) irq_in[1] = 1'b0;
    end
    sw_clr[1] = 1'b1;
    @(negedge clk);
    sw_clr[1] = 1'b0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      n_cmp++;
      if (pend_out !== m_pend || lost_out !== m_lost) begin
        n_err++;
        $display("FAIL random c=%0d pend=%h/%h lost=%h/%h (got/want)",
                 c, pend_out, m_pend, lost_out, m_lost);
      end
      irq_in   = irq_in ^ (V'($urandom) & V'($urandom));
      if ($urandom_range(0, 31) == 0) edge_mode = V'($urandom);
      sw_set   = V'($urandom) & V'($urandom) & V'($urandom) & V'($urandom);
      sw_clr   = V'($urandom) & V'($urandom) & V'($urandom) & V'($urandom);
      take_ack = ($urandom_range(0, 2) == 0);
      take_idx = $clog2(V)'($urandom);
      lost_clr = V'($urandom) & V'($urandom) & V'($urandom);
    end
    @(negedge clk);
    irq_in = '0; edge_mode = '1; sw_set = '0; sw_clr = '0;
    take_ack = 1'b0; lost_clr = '0;
  endtask

  task automatic test_reset_mid();
    lost_clr = '1;
    repeat (LAT + 2) @(negedge clk);
    lost_clr = '0;
    sw_clr   = '1;
    @(negedge clk);
    sw_clr    = '0;
    sw_set    = '1;
    irq_in[2] = 1'b1;
    irq_in[6] = 1'b1;
    @(negedge clk);
    sw_set = '0;
    repeat (LAT - 1) @(negedge clk);
    n_cmp++;
    if (pend_out !== '1 || lost_out !== 8'h44) begin
      n_err++; $display("FAIL pre_reset pend=%h lost=%h want=%h/44", pend_out, lost_out, {V{1'b1}});
    end
    irq_in[2] = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    n_cmp++;
    if (pend_out !== '0 || lost_out !== '0) begin
      n_err++; $display("FAIL async_reset pend=%h lost=%h want=0/0", pend_out, lost_out);
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    for (int c = 1; c <= LAT + 2; c++) begin
      @(negedge clk);
      n_cmp++;
      if (pend_out !== ((c >= LAT) ? 8'h40 : 8'h00) || pend_out !== m_pend) begin
        n_err++; $display("FAIL held_line c=%0d got=%h model=%h", c, pend_out, m_pend);
      end
    end
    take_ack = 1'b1;
    take_idx = 6;
    @(negedge clk);
    take_ack = 1'b0;
    repeat (5) @(negedge clk);
    n_cmp++;
    if (pend_out !== '0 || lost_out !== '0) begin
      n_err++; $display("FAIL single_edge pend=%h lost=%h want=0/0", pend_out, lost_out);
    end
  endtask

  initial begin
    test_reset();
    test_edge_basic();
    test_lost();
    test_level();
    test_sw();
    test_pulse();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/irq_pend_ctrl.md
# irq_pend_ctrl

Interrupt pend controller sitting directly upstream of the CLIC. It synchronises up to `VecSize` asynchronous external interrupt lines, performs per-line edge or level detection, and maintains the pend bit per vector. The CLIC entry CSRs consume the pend bits and acknowledge taken interrupts back into this block. It also records interrupts lost because an edge arrived on an already-pended vector.

## Interface
Parameters:
- `VecSize`, 8: number of interrupt lines/vectors; equals the CLIC vector count.
- `SyncStages`, 2: synchroniser flops per line (≥2).
- `FilterCycles`, 4: glitch-filter stability length (≥1); used only with the filter macro.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `irq_in`  in  VecSize  raw asynchronous interrupt lines.
- `edge_mode`  in  VecSize  per line: 1 = rising-edge triggered, 0 = level triggered (static CSR field).
- `sw_set`  in  VecSize  one-cycle software pend-set pulses.
- `sw_clr`  in  VecSize  one-cycle software pend-clear pulses.
- `take_ack`  in  1  CLIC took an interrupt this cycle.
- `take_idx`  in  $clog2(VecSize)  vector index taken.
- `lost_clr`  in  VecSize  one-cycle clears of the sticky lost flags.
- `pend_out`  out  VecSize  registered pend bits to the CLIC entries.
- `lost_out`  out  VecSize  sticky "edge while pended" flags.

## Operation
- Per line: `SyncStages`-deep synchroniser → (optional filter) → `lvl` (conditioned level) → `prev` register; rising edge = `lvl & ~prev`.
- Edge-mode pend next-state, per vector k, in priority order:
  - rising edge or `sw_set[k]` → 1.
  - else `sw_clr[k]`, or `take_ack && take_idx==k` → 0.
  - else hold.
  - A new edge coincident with an ack/clear therefore stays pended; no interrupt is lost.
- Level-mode pend next-state: `lvl[k] | sw_set[k]`. `take_ack` and `sw_clr` have no effect while the level is high. The source must deassert its line.
- Lost flag: set when, in edge mode, a rising edge occurs while `pend_out[k]`=1 and no ack/clear for k happens in the same cycle. Cleared by `lost_clr[k]`; set wins over a simultaneous clear.
- A `take_idx` ≥ VecSize is ignored.
- Changing `edge_mode[k]` takes effect on the next cycle. The pend value is retained across the switch.

## Timing
- Reset (reset=0, asynchronous): sync chains, filter state, `prev`, `pend_out`, `lost_out` all 0.
- A line held high through reset release produces one rising edge after synchronisation.
- Latency, raw rise to `pend_out`=1 in edge mode: `SyncStages`+1 cycles without the filter; `SyncStages`+`FilterCycles`+1 cycles with the filter.
- `sw_set`/`sw_clr`/`take_ack` affect `pend_out` on the next clock edge (1 cycle).
- All outputs are registered; there is no combinational path from inputs to outputs.
- Reset asserted mid-operation discards all pending and lost state immediately.

## Configuration
- `IRQ_PEND_GLITCH_FILTER_EN` defined:
  - Each line has a counter of width $clog2(FilterCycles+1).
  - `lvl` toggles only after the synchronised value has differed from `lvl` for `FilterCycles` consecutive cycles.
  - The counter clears whenever the values match.
  - Pulses shorter than `FilterCycles` cycles are dropped.
- Not defined: `lvl` = last synchroniser stage; no counters are instantiated.

## Structure
- `config_pkg` holds `IrqVecSize` (shared with the CLIC `VecSize`) and `irq_idx_t` (logic [$clog2(IrqVecSize)-1:0]).
- One sub-module, `irq_line_cond`: synchroniser plus optional filter for a single line, output `lvl`. It is instantiated VecSize times in a generate loop.
- Pend/lost logic stays in the top.

## Test plan
- Edge mode, no filter, `irq_in[3]` 0→1 at cycle 10 → `pend_out[3]`=1 at cycle 13. `take_ack`=1, `take_idx`=3 at cycle 20 → `pend_out[3]`=0 at cycle 21.
- Second rising edge on line 3 while pended → `lost_out[3]`=1. Edge in the same cycle as `take_ack` idx 3 → pend stays 1 and `lost_out` stays 0.
- Level mode line 5 held high: `take_ack` idx 5 → `pend_out[5]` remains 1. Drop line → `pend_out[5]`=0 three cycles later.
- `sw_set[0]` and `sw_clr[0]` in the same cycle → `pend_out[0]`=1. `sw_clr[0]` alone next → 0.
- Filter enabled, FilterCycles=4: 3-cycle pulse on line 1 → no pend. 6-cycle pulse → `pend_out[1]`=1 at SyncStages+5 after the rise.
- Assert reset mid-run with pends and lost flags set → all outputs 0 asynchronously. A line held high across release → one pend after release.
